// File: rtl/loader_pkg.sv
// loader_pkg: shared definitions for the boot-time program loader.
//   state_t          FSM state encoding of the loader
//   SIZE_IM_DEFAULT  default instruction-memory depth in words
//   WCNT_W           width of the word counter / words_loaded output
package loader_pkg;

   typedef enum logic [2:0] {
      S_COUNT = 3'd0,
      S_HI    = 3'd1,
      S_LO    = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   localparam int SIZE_IM_DEFAULT = 32;

   // Wide enough to hold SIZE_IM itself (a full memory), not just SIZE_IM-1.
   localparam int WCNT_W = 6;

endpackage

// File: rtl/program_loader.sv
// program_loader: boot-time instruction loader.
// Accepts a byte stream (COUNT N, N big-endian 16-bit words, CHECK byte),
// writes the words to instruction memory from address 0 and verifies that
// CHECK equals the XOR of COUNT and every data byte.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_valid/in_data/in_ready   byte stream handshake (accept = valid & ready)
//   im_we/im_addr/im_wdata      registered instruction-memory write port
//   ready           program loaded and checksum good (holds until reset)
//   error           bad count or bad checksum (holds until reset)
//   words_loaded    words written since reset
module program_loader
   import loader_pkg::*;
#(
   parameter int SIZE_IM = SIZE_IM_DEFAULT,
   parameter int ADDR_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [15:0]       im_wdata,
   output logic              ready,
   output logic              error,
   output logic [WCNT_W-1:0] words_loaded
);

   localparam logic [WCNT_W-1:0] WORD_ONE = WCNT_W'(1);

   state_t            state_q, state_d;
   logic              in_ready_q;
   logic              accept;
   logic              bad_count;
   logic              last_word;
   logic              cnt_en, hi_en, xor_en, wr_en;
   logic [7:0]        xor_q;
   logic [7:0]        hi_q;
   logic [WCNT_W-1:0] n_q;
   logic [WCNT_W-1:0] words_q;

   assign accept    = in_valid & in_ready_q;
   assign bad_count = (in_data == 8'd0) || (int'(in_data) > SIZE_IM);
   // Comparing the post-increment index against N means the counter never
   // needs to wrap: the last write lands at N-1 <= SIZE_IM-1.
   assign last_word = ((words_q + WORD_ONE) == n_q);

   // Next-state and per-byte enables
   always_comb begin
      state_d = state_q;
      cnt_en  = 1'b0;
      hi_en   = 1'b0;
      xor_en  = 1'b0;
      wr_en   = 1'b0;
      case (state_q)
         S_COUNT: begin
            if (accept) begin
               cnt_en  = 1'b1;
               xor_en  = 1'b1;
               state_d = bad_count ? S_ERR : S_HI;
            end
         end
         S_HI: begin
            if (accept) begin
               hi_en   = 1'b1;
               xor_en  = 1'b1;
               state_d = S_LO;
            end
         end
         S_LO: begin
            if (accept) begin
               xor_en  = 1'b1;
               wr_en   = 1'b1;
               state_d = last_word ? S_CHECK : S_HI;
            end
         end
         S_CHECK: begin
            if (accept) begin
               state_d = (in_data == xor_q) ? S_DONE : S_ERR;
            end
         end
         S_DONE:  state_d = S_DONE;
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // State register; in_ready is a registered decode of the next state so
   // it has no combinational path from in_valid and is low in reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_COUNT;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != S_DONE) && (state_d != S_ERR);
      end
   end

   // Byte assembly, checksum and write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         xor_q    <= 8'd0;
         hi_q     <= 8'd0;
         n_q      <= '0;
         words_q  <= '0;
         im_we    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= 16'd0;
      end else begin
         im_we <= wr_en;
         if (xor_en) begin
            xor_q <= xor_q ^ in_data;
         end
         if (cnt_en) begin
            n_q <= in_data[WCNT_W-1:0];
         end
         if (hi_en) begin
            hi_q <= in_data;
         end
         // Address and data hold their last values between writes.
         if (wr_en) begin
            im_addr  <= ADDR_W'(words_q);
            im_wdata <= {hi_q, in_data};
            words_q  <= words_q + WORD_ONE;
         end
      end
   end

   assign in_ready     = in_ready_q;
   assign ready        = (state_q == S_DONE);
   assign error        = (state_q == S_ERR);
   assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        im_we;
   logic [15:0] im_addr;
   logic [15:0] im_wdata;
   logic        ready;
   logic        error;
   logic [5:0]  words_loaded;

   program_loader #(.SIZE_IM(32), .ADDR_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .ready        (ready),
      .error        (error),
      .words_loaded (words_loaded)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   logic [15:0] wr_addr[$];
   logic [15:0] wr_data[$];
   int          wr_cyc[$];
   int          acc_cyc[$];
   logic [7:0]  stream[$];
   int          ready_cyc = -1;
   int          err_cyc   = -1;
   int          both_cnt  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observer: time-stamps every write and the first ready/error cycle.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (im_we === 1'b1) begin
         wr_addr.push_back(im_addr);
         wr_data.push_back(im_wdata);
         wr_cyc.push_back(cyc);
      end
      if (ready === 1'b1 && ready_cyc < 0) ready_cyc = cyc;
      if (error === 1'b1 && err_cyc < 0) err_cyc = cyc;
      if (ready === 1'b1 && error === 1'b1) both_cnt = both_cnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_obs();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      acc_cyc.delete();
      ready_cyc = -1;
      err_cyc   = -1;
      both_cnt  = 0;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, ".in_ready"},     32'(in_ready), 32'd0);
      check({tag, ".im_we"},        32'(im_we), 32'd0);
      check({tag, ".im_addr"},      32'(im_addr), 32'd0);
      check({tag, ".im_wdata"},     32'(im_wdata), 32'd0);
      check({tag, ".ready"},        32'(ready), 32'd0);
      check({tag, ".error"},        32'(error), 32'd0);
      check({tag, ".words_loaded"}, 32'(words_loaded), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;
      @(negedge clk);
      check_outputs_zero({tag, ".rst"});
      clear_obs();
      rst_n = 1'b1;
      @(negedge clk);
      check({tag, ".in_ready_after_rst"}, 32'(in_ready), 32'd1);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int t;
      repeat (gap) begin
         @(negedge clk);
         in_valid = 1'b0;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("in_ready_wait", 32'(in_ready), 32'd1);
      @(posedge clk);
      acc_cyc.push_back(cyc);
   endtask

   task automatic send_stream(input int gapmax);
      foreach (stream[i]) begin
         send_byte(stream[i], (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax)));
      end
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic build(input int n, input bit good);
      logic [7:0] x;
      logic [7:0] b;
      stream.delete();
      stream.push_back(8'(n));
      x = 8'(n);
      if (n == 0 || n > 32) return;
      for (int i = 0; i < 2 * n; i++) begin
         b = 8'($urandom);
         stream.push_back(b);
         x = x ^ b;
      end
      stream.push_back(good ? x : (x ^ (8'd1 << $urandom_range(0, 7))));
   endtask

   // Reference: derive the expected writes and verdict from the stream alone.
   task automatic verify(input string tag);
      int         n;
      int         nw;
      int         dec;
      bit         ok;
      logic [7:0] x;
      n = int'(stream[0]);
      if (n == 0 || n > 32) begin
         nw = 0; ok = 1'b0; dec = 0;
      end else begin
         x = 8'd0;
         for (int i = 0; i <= 2 * n; i++) x = x ^ stream[i];
         ok  = (stream[2 * n + 1] == x);
         nw  = n;
         dec = 2 * n + 1;
      end
      check({tag, ".n_writes"}, 32'(wr_addr.size()), 32'(nw));
      for (int i = 0; i < nw; i++) begin
         if (i < wr_addr.size()) begin
            check($sformatf("%s.addr%0d", tag, i), 32'(wr_addr[i]), 32'(i));
            check($sformatf("%s.data%0d", tag, i), 32'(wr_data[i]),
                  32'({stream[1 + 2 * i], stream[2 + 2 * i]}));
            check($sformatf("%s.wcyc%0d", tag, i), 32'(wr_cyc[i]), 32'(acc_cyc[2 + 2 * i] + 1));
         end
      end
      check({tag, ".ready"},        32'(ready), 32'(ok));
      check({tag, ".error"},        32'(error), 32'(!ok));
      check({tag, ".words_loaded"}, 32'(words_loaded), 32'(nw));
      check({tag, ".in_ready"},     32'(in_ready), 32'd0);
      check({tag, ".decide_cyc"},   32'(ok ? ready_cyc : err_cyc), 32'(acc_cyc[dec] + 1));
      check({tag, ".exclusive"},    32'(both_cnt), 32'd0);
      // Bytes offered in a terminal state must be ignored.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      repeat (3) @(negedge clk);
      in_valid = 1'b0;
      check({tag, ".post_writes"}, 32'(wr_addr.size()), 32'(nw));
      check({tag, ".post_words"},  32'(words_loaded), 32'(nw));
      check({tag, ".post_ready"},  32'(ready), 32'(ok));
   endtask

   task automatic load_happy(input logic [7:0] chk);
      stream.delete();
      stream.push_back(8'h02); stream.push_back(8'h21); stream.push_back(8'h05);
      stream.push_back(8'h51); stream.push_back(8'h02); stream.push_back(chk);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'd0;

      // Reset state
      do_reset("init");

      // Happy path, N=2
      load_happy(8'h75);
      send_stream(0);
      check("happy.w0_const", 32'(wr_data.size() > 0 ? wr_data[0] : 16'hxxxx), 32'h2105);
      check("happy.w1_const", 32'(wr_data.size() > 1 ? wr_data[1] : 16'hxxxx), 32'h5102);
      verify("happy");

      // Bad checksum
      do_reset("badchk");
      load_happy(8'h74);
      send_stream(0);
      verify("badchk");

      // Bad counts: zero and one above capacity
      do_reset("cnt0");
      build(0, 1'b1);
      send_stream(0);
      verify("cnt0");

      do_reset("cnt33");
      build(33, 1'b1);
      send_stream(0);
      verify("cnt33");

      // Happy path with idle gaps
      do_reset("gaps");
      load_happy(8'h75);
      send_stream(4);
      verify("gaps");

      // Full memory
      do_reset("full");
      build(32, 1'b1);
      send_stream(0);
      check("full.last_addr", 32'(wr_addr.size() > 0 ? wr_addr[wr_addr.size() - 1] : 16'hxxxx), 32'd31);
      verify("full");

      // Random programs, random checksums and gaps
      for (int k = 0; k < 6; k++) begin
         do_reset($sformatf("rnd%0d", k));
         build(int'($urandom_range(1, 32)), ($urandom_range(0, 3) != 0));
         send_stream(int'($urandom_range(0, 2)));
         verify($sformatf("rnd%0d", k));
      end

      do_reset("rndcnt");
      build(int'($urandom_range(33, 255)), 1'b1);
      send_stream(1);
      verify("rndcnt");

      // Reset on the cycle the second low byte is accepted
      do_reset("midrst");
      load_happy(8'h75);
      for (int i = 0; i < 4; i++) send_byte(stream[i], 0);
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'h02;
      @(negedge clk);
      check_outputs_zero("midrst.during");
      check("midrst.one_write", 32'(wr_addr.size()), 32'd1);
      in_valid = 1'b0;
      do_reset("midrst2");
      load_happy(8'h75);
      send_stream(0);
      verify("midrst_reload");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader for the single-cycle processor. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, writes them into instruction memory starting at address 0, and verifies an XOR checksum. On success it raises `ready`, which releases the processor's PC and fetch logic from their held-at-zero state. It sits directly upstream of the processor's `ready` input and the instruction-memory write port.

## Interface
- `SIZE_IM`, 32: instruction-memory depth in words; the maximum program length.
- `ADDR_W`, 16: instruction-memory address width, matching the PC width.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  a byte is present on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  the loader can accept a byte this cycle.
- `im_we`  out  1  instruction-memory write strobe, one cycle wide.
- `im_addr`  out  ADDR_W  write address.
- `im_wdata`  out  16  instruction word to write.
- `ready`  out  1  program loaded and checksum good; processor may run.
- `error`  out  1  load aborted (bad count or bad checksum).
- `words_loaded`  out  6  number of words written since reset.

## Operation
- Stream format: one COUNT byte N, then N words sent high byte first, then one CHECK byte.
- CHECK must equal the XOR of COUNT and all 2N data bytes.
- A byte is accepted on a posedge where `in_valid & in_ready` is high; nothing else advances state.
- FSM states and transitions:
  - S_COUNT: accept N. If N is 0 or N > SIZE_IM, go to S_ERR; otherwise go to S_HI.
  - S_HI: latch the high byte, then go to S_LO.
  - S_LO: latch the low byte and issue the write. If this was word N, go to S_CHECK; otherwise go to S_HI.
  - S_CHECK: compare the accepted byte with the running XOR. On a match go to S_DONE; otherwise go to S_ERR.
  - S_DONE and S_ERR: terminal. They are left only via reset.
- Address counter:
  - Starts at 0 and increments after each write.
  - The word index is compared against the latched N, so there is no wrap-around. The last possible address is SIZE_IM-1.
- `words_loaded` increments together with each `im_we` pulse. It saturates naturally at SIZE_IM.
- Running XOR is an 8-bit register. It is cleared on reset and updated on every accepted COUNT and data byte.
- Bytes offered in S_DONE or S_ERR are not accepted (`in_ready`=0).
- Reset mid-load:
  - Returns the FSM to S_COUNT and clears all counters and the XOR.
  - Any `im_we` pending in the same cycle is suppressed.
  - Words already written to memory are not erased.
- Memory contents after an error are undefined; `ready` stays 0.

## Timing
- Reset values: `in_ready`=0 during the reset cycle and 1 on the first cycle after it. All other outputs are 0: `im_we`, `im_addr`, `im_wdata`, `ready`, `error`, `words_loaded`.
- `in_ready` is 1 in S_COUNT, S_HI, S_LO and S_CHECK, and 0 in S_DONE and S_ERR. It is a registered state decode with no combinational path from `in_valid`.
- Write latency: `im_we`, `im_addr` and `im_wdata` are registered. They are valid for exactly the one cycle after the low byte is accepted.
- `im_addr` and `im_wdata` hold their last values when `im_we`=0.
- `ready` and `error` rise the cycle after the deciding byte is accepted (CHECK, or COUNT for a bad count). They are mutually exclusive and stay high until reset.
- The last write always precedes `ready`: CHECK can be accepted no earlier than the cycle of the last `im_we`.
- Full rate: one byte per cycle, so a program of N words takes 2N+2 accepted bytes.

## Structure
- Shared package `loader_pkg`:
  - FSM state encodings S_COUNT, S_HI, S_LO, S_CHECK, S_DONE, S_ERR.
  - Default SIZE_IM.
  - Width constant for `words_loaded`.
- Single module; no sub-module is required.
- `Top` instantiates the loader and routes its `ready` into the existing Controller and Datapath `ready`.
- The instruction memory gains a write port driven by `im_we`, `im_addr` and `im_wdata`.

## Test plan
- Happy path, N=2:
  - Stimulus: bytes 02, 21, 05, 51, 02, then CHECK 75.
  - Writes: addr0=0x2105, addr1=0x5102.
  - Response: `ready`=1 one cycle after 75 is accepted, `words_loaded`=2, `error`=0.
- Bad checksum: same stream with CHECK 74 → `error`=1, `ready`=0, both writes still occur, `in_ready`=0 afterwards.
- Bad count:
  - COUNT 00 → `error`=1 next cycle, no `im_we`.
  - COUNT 21 (33) → `error`=1 next cycle, no `im_we`.
- Backpressure/gaps: the happy-path stream with random `in_valid` idle cycles between bytes → identical writes and `ready` timing relative to the last accepted byte.
- Full memory:
  - Stimulus: N=32 words with a correct checksum.
  - Response: last write at addr 31, `words_loaded`=32, `ready`=1.
- Reset mid-load:
  - Stimulus: assert `rst_n`=0 on the cycle the second low byte is accepted.
  - Response: no second `im_we`; all outputs return to 0. A subsequent full happy-path stream succeeds.
